highway_road_controller: RTL and testbench
==========================================

// Module: highway_road_controller
// PURPOSE
//  Highway-side light FSM of the two-road traffic-light system; the peer of the country-road controller.
//  Highway rests GREEN. It yields only when a country-road car is waiting and the minimum green time has elapsed.
//  It hands the right of way over with enable_n, and takes it back when the country side returns enable_h.
//  Drives the highway lamp code, a 2-digit BCD countdown display and the timer start pulse.
// PARAMETERS
//  T_GREEN_MIN  8'h30  highway minimum-green display preset, BCD
//  T_YELLOW     8'h05  highway yellow display preset, BCD
//  T_RED        8'h35  highway red display preset, BCD (country green + country yellow)
// PORTS
//  clk        in   1  system clock, one tick = 1 s; all logic on posedge
//  rst_n      in   1  asynchronous, active-low reset
//  car        in   1  country-road car sensor, level
//  Timeout    in   1  long-interval timer expired (pulse or level)
//  timeout    in   1  short-interval timer expired (pulse or level)
//  enable_h   in   1  from country controller: country has finished yellow, highway may go green
//  enable_n   out  1  to country controller: highway is red, country may go green (1-cycle pulse)
//  start_h    out  1  restart the shared interval timer (1-cycle pulse)
//  count_hw   out  8  BCD countdown display {tens,units}
//  color_hw   out  3  one-hot lamp: 100 GREEN, 010 YELLOW, 001 RED
//  proto_err  out  1  sticky: enable_h seen outside RED
// BEHAVIOUR
//  Reset values (async):
//   - state GREEN, color_hw=100, count_hw=T_GREEN_MIN
//   - enable_n=0, start_h=0, proto_err=0, min_done=0
//  Registers: all outputs registered; a qualifying input at edge k is visible after edge k+1.
//  Pulses: enable_n and start_h are 0 in every cycle except a transition cycle.
//  GREEN:
//   - Timeout=1 sets min_done (sticky; Timeout may be a 1-cycle pulse).
//   - If (Timeout|min_done) & car:
//     -> YELLOW, start_h=1, count_hw=T_YELLOW, color_hw=010, min_done cleared.
//   - Otherwise count_hw decrements; timeout is ignored.
//   - Timeout & car in the same cycle -> YELLOW immediately.
//   - car dropping before Timeout -> stay GREEN.
//  YELLOW:
//   - timeout=1 -> RED, enable_n=1, count_hw=T_RED, color_hw=001.
//   - Otherwise decrement; Timeout and car are ignored.
//  RED:
//   - enable_h=1 -> GREEN, start_h=1, count_hw=T_GREEN_MIN, color_hw=100.
//   - Otherwise decrement.
//   - enable_n is not re-pulsed while waiting.
//  Protocol error:
//   - enable_h=1 in GREEN or YELLOW sets proto_err (sticky until reset).
//   - State is unchanged and the input is otherwise ignored.
//  Countdown (BCD decrement, saturating):
//   - Units 0 -> 9 with borrow from tens (e.g. 8'h10 -> 8'h09).
//   - 8'h00 holds at 8'h00 (long GREEN with no car shows 00).
//   - Non-BCD nibbles are out of contract.
//  Loads: a state-transition load takes priority over the decrement in the same cycle.
//  Reset mid-operation: returns to GREEN/T_GREEN_MIN at once; any pulse in flight is dropped.
//  Illegal state encoding: recover to GREEN with reset values, proto_err=1.
// STRUCTURE
//  Package traffic_pkg:
//   - lamp codes GREEN/YELLOW/RED (3'b100/010/001)
//   - highway state encodings
//   - default BCD timing constants, shared with the country-road controller
//  Sub-module bcd_dec_sat:
//   - combinational 8-bit two-digit BCD saturating decrement
//   - instantiated once on count_hw
//  Top level: one state register block plus output registers; no other hierarchy.
// TESTING
//  1. Reset, rst_n=0 -> color_hw=100, count_hw=8'h30, enable_n=0, start_h=0, proto_err=0.
//  2. GREEN, car=0, Timeout 1-cycle pulse, car=1 ten cycles later
//     -> next edge: color_hw=010, count_hw=8'h05, start_h high exactly 1 cycle.
//  3. YELLOW, timeout=1 -> color_hw=001, count_hw=8'h35, enable_n high exactly 1 cycle;
//     then 8'h35 -> 8'h34 ... 8'h10 -> 8'h09.
//  4. RED, enable_h=1 -> color_hw=100, count_hw=8'h30, start_h 1-cycle pulse; enable_n stays 0.
//  5. GREEN, no car for 40 cycles -> count_hw saturates at 8'h00;
//     enable_h=1 pulse -> proto_err=1, color_hw stays 100.
//  6. rst_n low during YELLOW -> immediately color_hw=100, count_hw=8'h30, proto_err=0;
//     car=1 with no Timeout after release -> remains GREEN.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp codes, highway state encodings and default BCD timing presets
// for the two-road traffic-light controllers.
package traffic_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;

  typedef enum logic [1:0] {
    HW_GREEN  = 2'd0,
    HW_YELLOW = 2'd1,
    HW_RED    = 2'd2
  } hw_state_t;

  localparam logic [7:0] DEF_T_GREEN_MIN = 8'h30;
  localparam logic [7:0] DEF_T_YELLOW    = 8'h05;
  localparam logic [7:0] DEF_T_RED       = 8'h35;

endpackage

// File: rtl/bcd_dec_sat.sv
// Two-digit BCD decrement that saturates at 00.
module bcd_dec_sat (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_comb begin
    dout = din;
    if (din == 8'h00) begin
      dout = 8'h00;
    end else if (din[3:0] == 4'h0) begin
      dout = {din[7:4] - 4'h1, 4'h9};
    end else begin
      dout = {din[7:4], din[3:0] - 4'h1};
    end
  end

endmodule

// File: rtl/highway_road_controller.sv
// Highway-side light FSM: rests green, yields to a waiting country car after
// the minimum green time, and regains right of way on enable_h.
//
// state     | meaning
// ----------+-------------------------------------------------
// HW_GREEN  | highway green, waiting for min time and a car
// HW_YELLOW | highway yellow, waiting for short timer
// HW_RED    | highway red, country owns the road until enable_h
module highway_road_controller
  import traffic_pkg::*;
#(
  parameter logic [7:0] T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter logic [7:0] T_YELLOW    = DEF_T_YELLOW,
  parameter logic [7:0] T_RED       = DEF_T_RED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car,
  input  logic       Timeout,
  input  logic       timeout,
  input  logic       enable_h,
  output logic       enable_n,
  output logic       start_h,
  output logic [7:0] count_hw,
  output logic [2:0] color_hw,
  output logic       proto_err
);

  hw_state_t  state;
  logic       min_done;
  logic [7:0] count_dec;

  bcd_dec_sat u_dec (
    .din  (count_hw),
    .dout (count_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HW_GREEN;
      color_hw  <= LAMP_GREEN;
      count_hw  <= T_GREEN_MIN;
      enable_n  <= 1'b0;
      start_h   <= 1'b0;
      proto_err <= 1'b0;
      min_done  <= 1'b0;
    end else begin
      enable_n <= 1'b0;
      start_h  <= 1'b0;
      case (state)
        HW_GREEN: begin
          if (enable_h) proto_err <= 1'b1;
          if ((Timeout || min_done) && car) begin
            state    <= HW_YELLOW;
            start_h  <= 1'b1;
            count_hw <= T_YELLOW;
            color_hw <= LAMP_YELLOW;
            min_done <= 1'b0;
          end else begin
            if (Timeout) min_done <= 1'b1;
            count_hw <= count_dec;
          end
        end
        HW_YELLOW: begin
          if (enable_h) proto_err <= 1'b1;
          if (timeout) begin
            state    <= HW_RED;
            enable_n <= 1'b1;
            count_hw <= T_RED;
            color_hw <= LAMP_RED;
          end else begin
            count_hw <= count_dec;
          end
        end
        HW_RED: begin
          if (enable_h) begin
            state    <= HW_GREEN;
            start_h  <= 1'b1;
            count_hw <= T_GREEN_MIN;
            color_hw <= LAMP_GREEN;
          end else begin
            count_hw <= count_dec;
          end
        end
        default: begin
          // Corrupted encoding: restart as if reset, but flag it.
          state     <= HW_GREEN;
          color_hw  <= LAMP_GREEN;
          count_hw  <= T_GREEN_MIN;
          min_done  <= 1'b0;
          proto_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_highway_road_controller.sv
// Directed bench for highway_road_controller with hand-computed expectations.
module tb_highway_road_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       car = 1'b0;
  logic       Timeout = 1'b0;
  logic       timeout = 1'b0;
  logic       enable_h = 1'b0;
  logic       enable_n;
  logic       start_h;
  logic [7:0] count_hw;
  logic [2:0] color_hw;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  highway_road_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .car       (car),
    .Timeout   (Timeout),
    .timeout   (timeout),
    .enable_h  (enable_h),
    .enable_n  (enable_n),
    .start_h   (start_h),
    .count_hw  (count_hw),
    .color_hw  (color_hw),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int d);
    to_bcd = 8'((d / 10) * 16 + (d % 10));
  endfunction

  int d;
  int pulses;

  initial begin
    // 1. reset values while reset held
    #12;
    chk("rst_color", color_hw, 8'h04);
    chk("rst_count", count_hw, 8'h30);
    chk("rst_enable_n", enable_n, 8'h0);
    chk("rst_start_h", start_h, 8'h0);
    chk("rst_proto_err", proto_err, 8'h0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_count", count_hw, 8'h29);

    // 2. Timeout pulse with no car, car arrives ten cycles later
    Timeout = 1'b1;
    step();
    Timeout = 1'b0;
    chk("green_timeout_nocar_color", color_hw, 8'h04);
    chk("green_count_a", count_hw, 8'h28);
    for (int i = 0; i < 9; i++) step();
    chk("green_count_b", count_hw, 8'h19);
    chk("green_still_green", color_hw, 8'h04);
    car = 1'b1;
    step();
    chk("yellow_color", color_hw, 8'h02);
    chk("yellow_count", count_hw, 8'h05);
    chk("yellow_start_h", start_h, 8'h1);
    Timeout = 1'b1;
    step();
    Timeout = 1'b0;
    car = 1'b0;
    chk("yellow_start_h_drop", start_h, 8'h0);
    chk("yellow_ignores_Timeout", color_hw, 8'h02);
    chk("yellow_count_dec", count_hw, 8'h04);

    // 3. yellow -> red, then countdown 35 .. 09
    timeout = 1'b1;
    step();
    timeout = 1'b0;
    chk("red_color", color_hw, 8'h01);
    chk("red_count", count_hw, 8'h35);
    chk("red_enable_n", enable_n, 8'h1);
    d = 35;
    pulses = 0;
    while (d > 9) begin
      step();
      d--;
      if (enable_n) pulses++;
      chk("red_countdown", count_hw, to_bcd(d));
    end
    chk("red_enable_n_single", 8'(pulses), 8'h0);
    chk("red_color_hold", color_hw, 8'h01);

    // 4. enable_h hands right of way back
    enable_h = 1'b1;
    step();
    enable_h = 1'b0;
    chk("regreen_color", color_hw, 8'h04);
    chk("regreen_count", count_hw, 8'h30);
    chk("regreen_start_h", start_h, 8'h1);
    chk("regreen_enable_n", enable_n, 8'h0);
    chk("regreen_proto_err", proto_err, 8'h0);
    step();
    chk("regreen_start_h_drop", start_h, 8'h0);
    chk("regreen_count_dec", count_hw, 8'h29);

    // 5. long green saturates; enable_h in green is a protocol error
    d = 29;
    for (int i = 0; i < 40; i++) begin
      step();
      if (d > 0) d--;
    end
    chk("green_saturate", count_hw, to_bcd(d));
    chk("green_saturate_zero", count_hw, 8'h00);
    enable_h = 1'b1;
    step();
    enable_h = 1'b0;
    chk("proto_err_set", proto_err, 8'h1);
    chk("proto_err_color", color_hw, 8'h04);
    step();
    chk("proto_err_sticky", proto_err, 8'h1);

    // 6. same-cycle Timeout & car, then reset mid-yellow
    Timeout = 1'b1;
    car = 1'b1;
    step();
    Timeout = 1'b0;
    chk("same_cycle_yellow", color_hw, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_color", color_hw, 8'h04);
    chk("midrst_count", count_hw, 8'h30);
    chk("midrst_proto_err", proto_err, 8'h0);
    chk("midrst_start_h", start_h, 8'h0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("postrst_car_no_Timeout", color_hw, 8'h04);
    chk("postrst_start_h", start_h, 8'h0);
    chk("postrst_count", count_hw, 8'h25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
